unidade_pc: RTL
===============

Name: unidade_pc

Overview:
- Program-counter / next-address stage that consumes the control unit's `controle_pi`, `pausaPC` and `swap_P` outputs, and generates the fetch address.
- Adds a preemption quantum timer for user processes. On expiry it saves the interrupted next-PC and forces a jump to the OS entry.
- It drives `swap_SO` back to the control unit, which gates the IN/OUT CH0 handshake during a swap.

Parameters:
- ADDR_W, 10, width of instruction-memory address / PC
- QUANTUM, 64, user instructions executed before preemption (must be ≥1)
- SO_BASE, 0, PC loaded at reset and on every preemption

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- pausaPC  input  1  1 = run, 0 = hold PC (I/O wait)
- controle_pi  input  3  next-PC select: 0 PC+1, 1 imm16, 2 jaddr, 3 reg_rs, 4 end_ret
- swap_P  input  1  resume user process (enter user mode, reload quantum)
- imm  input  16  instr[15:0], absolute branch/jal target
- jaddr  input  26  instr[25:0], absolute jump target
- reg_rs  input  32  R[rs], jump-register target
- end_ret  input  32  saved return address of process being resumed
- pc  output  ADDR_W  current fetch address
- pc_mais1  output  ADDR_W  pc+1, combinational (jal link value)
- swap_SO  output  1  one-cycle preemption pulse
- pc_salvo  output  ADDR_W  next-PC captured at preemption, held until next preemption
- modo_user  output  1  1 while a user process runs
- quantum_rest  output  16  remaining user instructions

Behaviour:
- Reset (async, immediate) sets the following:
  - pc=SO_BASE
  - state=SO
  - modo_user=0
  - swap_SO=0
  - pc_salvo=0
  - quantum_rest=0
- Target truncation: all targets are truncated to ADDR_W LSBs. imm is zero-extended. PC+1 wraps from 2^ADDR_W-1 to 0.
- Illegal controle_pi values 5–7 select PC+1.
- nxt is the mux result selected by controle_pi. It is computed combinationally each cycle.
- States: SO, USER, TROCA.
- SO state:
  - If pausaPC=1: pc<=nxt.
  - If swap_P=1 and pausaPC=1: pc<=end_ret[ADDR_W-1:0], quantum_rest<=QUANTUM, go to USER, modo_user<=1.
  - If pausaPC=0: pc holds and swap_P is ignored.
- USER state:
  - If pausaPC=0: pc and quantum_rest hold. The timer never expires while paused.
  - If pausaPC=1 and quantum_rest>1: pc<=nxt, quantum_rest decrements.
  - If pausaPC=1 and quantum_rest==1: the instruction completes. pc_salvo<=nxt (a taken branch/jump target is saved, not PC+1), pc<=SO_BASE, quantum_rest<=0, swap_SO<=1, go to TROCA.
  - swap_P=1 in USER acts as a plain pi=4 jump and reloads quantum_rest=QUANTUM. It takes priority over expiry.
- TROCA state:
  - Lasts exactly one cycle. swap_SO=1 and modo_user=0.
  - pc holds SO_BASE regardless of inputs.
  - Next state is SO, and swap_SO<=0.
- swap_SO is registered: high exactly one cycle after the expiring instruction's edge.
- Latency: pc updates on the edge after the selecting instruction is presented. There is no bubble except during TROCA.

Decomposition:
- Shared package pc_pkg holds:
  - controle_pi encodings: PI_SEQ=0, PI_IMM=1, PI_JMP=2, PI_REG=3, PI_RET=4
  - state enum {SO, USER, TROCA}
  - quantum width constant 16
- One sub-module, prox_pc_mux: combinational next-PC selector with wrap/truncate rules. The FSM and timer stay in unidade_pc.

Test Plan:
- Reset: rst pulse mid-cycle with pc=37 → pc=0, swap_SO=0, modo_user=0 asynchronously.
- Sequential/branch/pause, with pc=5:
  - pi=0 → pc=6
  - pi=1, imm=0x0020 → pc=32
  - pi=3, reg_rs=0xFFFF_F003 (ADDR_W=10) → pc=3
  - pausaPC=0 for 4 cycles → pc stays 3
- Resume: in SO, swap_P=1, end_ret=100 → pc=100, modo_user=1, quantum_rest=64.
- Preemption:
  - QUANTUM=3, user code pi=0 from 100 → pc 101, 102, then pc=0 with swap_SO=1 for one cycle, pc_salvo=103.
  - Next cycle: state SO, swap_SO=0.
- Expiry coinciding with a branch: last quantum instruction has pi=2, jaddr=200 → pc_salvo=200, pc=SO_BASE.
- Pause at quantum_rest=1: pausaPC=0 for 5 cycles → no swap_SO. On pausaPC=1 the expiry occurs on that edge. Also check wrap: pc=1023, pi=0 → pc=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: next-PC select codes,
// FSM state encoding and the quantum counter width.
// No logic lives here.
package pc_pkg;

    // Width of the preemption quantum counter
    localparam int QW = 16;

    // controle_pi encodings; codes 5-7 fall back to sequential fetch
    localparam logic [2:0] PI_SEQ = 3'd0;
    localparam logic [2:0] PI_IMM = 3'd1;
    localparam logic [2:0] PI_JMP = 3'd2;
    localparam logic [2:0] PI_REG = 3'd3;
    localparam logic [2:0] PI_RET = 3'd4;

    // SO: OS code running, USER: user process under quantum, TROCA: swap cycle
    typedef enum logic [1:0] {
        SO    = 2'd0,
        USER  = 2'd1,
        TROCA = 2'd2
    } estado_t;

endpackage

// File: rtl/prox_pc_mux.sv
// Next-PC selector: picks PC+1 or one of the jump targets, truncated to ADDR_W.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is loaded.
module prox_pc_mux
    import pc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [2:0]        sel_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       jaddr_i,
    input  logic [31:0]       reg_rs_i,
    input  logic [31:0]       end_ret_i,
    output logic [ADDR_W-1:0] pc_mais1_o,
    output logic [ADDR_W-1:0] nxt_o
);

    // Targets are widened to 32 bits first so truncation works for any ADDR_W <= 32
    logic [31:0] imm_ext;
    logic [31:0] jaddr_ext;

    assign imm_ext    = {16'd0, imm_i};
    assign jaddr_ext  = {6'd0, jaddr_i};
    // Natural modulo-2^ADDR_W wrap from the top address back to 0
    assign pc_mais1_o = pc_i + ADDR_W'(1);

    // Select the next fetch address; unknown codes behave as sequential fetch
    always_comb begin
        nxt_o = pc_mais1_o;
        case (sel_i)
            PI_SEQ:  nxt_o = pc_mais1_o;
            PI_IMM:  nxt_o = imm_ext[ADDR_W-1:0];
            PI_JMP:  nxt_o = jaddr_ext[ADDR_W-1:0];
            PI_REG:  nxt_o = reg_rs_i[ADDR_W-1:0];
            PI_RET:  nxt_o = end_ret_i[ADDR_W-1:0];
            default: nxt_o = pc_mais1_o;
        endcase
    end

endmodule

// File: rtl/unidade_pc.sv
// PC stage with user-process quantum timer: on expiry saves next-PC and jumps to the OS.
// Latency: pc updates on the edge after the selecting instruction; one-cycle TROCA bubble on preemption.
// Backpressure: pausaPC=0 freezes pc and the quantum timer (swap_P ignored in SO while paused).
module unidade_pc
    import pc_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter int unsigned QUANTUM = 64,
    parameter int unsigned SO_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pausaPC,
    input  logic [2:0]        controle_pi,
    input  logic              swap_P,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    input  logic [31:0]       reg_rs,
    input  logic [31:0]       end_ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_mais1,
    output logic              swap_SO,
    output logic [ADDR_W-1:0] pc_salvo,
    output logic              modo_user,
    output logic [QW-1:0]     quantum_rest
);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(SO_BASE);
    localparam logic [QW-1:0]     Q_INI = QW'(QUANTUM);

    estado_t           state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] salvo_q, salvo_d;
    logic [QW-1:0]     quant_q, quant_d;
    logic              swap_q, swap_d;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] ret_addr;

    prox_pc_mux #(
        .ADDR_W (ADDR_W)
    ) u_mux (
        .pc_i       (pc_q),
        .sel_i      (controle_pi),
        .imm_i      (imm),
        .jaddr_i    (jaddr),
        .reg_rs_i   (reg_rs),
        .end_ret_i  (end_ret),
        .pc_mais1_o (pc_mais1),
        .nxt_o      (nxt)
    );

    // Resuming a process always jumps to its saved return address, whatever controle_pi says
    assign ret_addr = end_ret[ADDR_W-1:0];

    // FSM, PC and quantum next-state; swap_P beats expiry in USER
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        salvo_d = salvo_q;
        quant_d = quant_q;
        swap_d  = 1'b0;
        case (state_q)
            SO: begin
                if (pausaPC) begin
                    if (swap_P) begin
                        pc_d    = ret_addr;
                        quant_d = Q_INI;
                        state_d = USER;
                    end else begin
                        pc_d = nxt;
                    end
                end
            end
            USER: begin
                if (pausaPC) begin
                    if (swap_P) begin
                        pc_d    = ret_addr;
                        quant_d = Q_INI;
                    end else if (quant_q > QW'(1)) begin
                        pc_d    = nxt;
                        quant_d = quant_q - QW'(1);
                    end else begin
                        // Last instruction of the quantum completes; its real successor is saved
                        salvo_d = nxt;
                        pc_d    = BASE;
                        quant_d = '0;
                        swap_d  = 1'b1;
                        state_d = TROCA;
                    end
                end
            end
            TROCA: begin
                pc_d    = BASE;
                state_d = SO;
            end
            default: begin
                pc_d    = BASE;
                state_d = SO;
            end
        endcase
    end

    // State registers with asynchronous reset into OS mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SO;
            pc_q    <= BASE;
            salvo_q <= '0;
            quant_q <= '0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            salvo_q <= salvo_d;
            quant_q <= quant_d;
            swap_q  <= swap_d;
        end
    end

    assign pc           = pc_q;
    assign pc_salvo     = salvo_q;
    assign quantum_rest = quant_q;
    assign swap_SO      = swap_q;
    assign modo_user    = (state_q == USER);

endmodule
